// File: rtl/mem_io_arb_pkg.sv
// Shared definitions for the memory/IO arbiter: defaults, FSM encoding,
// abort read value and watchdog counter width.
package mem_io_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 14;
  localparam int unsigned IO_AW_DEF      = 10;
  localparam int unsigned IO_TIMEOUT_DEF = 255;
  localparam int unsigned TIMER_W        = 8;

  // Read data returned to the CPU when an IO access is aborted.
  localparam logic [31:0] RDATA_ABORT = 32'h0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MEM_RD  = 3'd1;
  localparam logic [2:0] ST_IO_WAIT = 3'd2;
  localparam logic [2:0] ST_IO_DONE = 3'd3;
  localparam logic [2:0] ST_UPG     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_MEM_RD  = ST_MEM_RD,
    S_IO_WAIT = ST_IO_WAIT,
    S_IO_DONE = ST_IO_DONE,
    S_UPG     = ST_UPG
  } state_e;

endpackage

// File: rtl/arb_io_timer.sv
// IO watchdog timer, used only when MEM_IO_ARB_WATCHDOG_EN is defined.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : restart the count from zero (new IO request issued)
//   count      : advance one step per cycle while the request is outstanding
//   expire_c   : combinational, high on the LIMIT-th counted cycle
module arb_io_timer
  import mem_io_arb_pkg::*;
#(
  parameter int unsigned LIMIT = IO_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire_c
);

  logic [TIMER_W-1:0] cnt_q;

  // Counter value k-1 during the k-th waiting cycle; saturates on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (count && !expire_c) begin
      cnt_q <= cnt_q + TIMER_W'(1);
    end
  end

  assign expire_c = count && (cnt_q == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/mem_io_arbiter.sv
// Shares the data BRAM port and the MMIO bus between the CPU load/store path
// and the UART program loader, stalling the CPU while an access is in flight
// or while the loader owns memory.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   cpu_mem_read/write, cpu_io_read/write, cpu_addr, cpu_wdata : CPU request
//   cpu_rdata, cpu_stall           : load data and pipeline hold
//   upg_active/valid/addr/wdata, upg_ready : loader write channel
//   mem_en/we/addr/wdata, mem_rdata : BRAM port (1-cycle read latency)
//   io_req/we/addr/wdata, io_rdata, io_ack : IO level-request handshake
//   err_timeout                    : sticky IO watchdog error
// Build option: define MEM_IO_ARB_WATCHDOG_EN to abort IO accesses that are not
// acknowledged within IO_TIMEOUT cycles; otherwise IO waits indefinitely.
module mem_io_arbiter
  import mem_io_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned IO_AW      = IO_AW_DEF,
  parameter int unsigned IO_TIMEOUT = IO_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic              cpu_io_read,
  input  logic              cpu_io_write,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              upg_active,
  input  logic              upg_valid,
  input  logic [ADDR_W-1:0] upg_addr,
  input  logic [31:0]       upg_wdata,
  output logic              upg_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [IO_AW-1:0]  io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack,
  output logic              err_timeout
);

  state_e      state_q, state_d;
  logic [31:0] rdata_q;
  logic        io_issue, io_complete, io_abort, rd_capture, st_clear;
  logic        wd_expire_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and access sequencing. IDLE decode is gated by rst_n so every
  // output reads zero while reset is asserted, even with a request pending.
  always_comb begin
    state_d     = state_q;
    cpu_stall   = 1'b0;
    upg_ready   = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = cpu_addr[ADDR_W+1:2];
    mem_wdata   = cpu_wdata;
    cpu_rdata   = rdata_q;
    io_issue    = 1'b0;
    io_complete = 1'b0;
    io_abort    = 1'b0;
    rd_capture  = 1'b0;
    st_clear    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rst_n) begin
          if (upg_active) begin
            cpu_stall = 1'b1;
            state_d   = S_UPG;
          end else if (cpu_mem_write) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            st_clear = 1'b1;
          end else if (cpu_mem_read) begin
            mem_en    = 1'b1;
            cpu_stall = 1'b1;
            state_d   = S_MEM_RD;
          end else if (cpu_io_read || cpu_io_write) begin
            cpu_stall = 1'b1;
            io_issue  = 1'b1;
            state_d   = S_IO_WAIT;
          end
        end
      end
      S_MEM_RD: begin
        cpu_rdata  = mem_rdata;
        rd_capture = 1'b1;
        state_d    = S_IDLE;
      end
      S_IO_WAIT: begin
        cpu_stall = 1'b1;
        if (io_ack) begin
          io_complete = 1'b1;
          state_d     = S_IO_DONE;
        end else if (wd_expire_c) begin
          io_abort = 1'b1;
          state_d  = S_IO_DONE;
        end
      end
      // One unstalled cycle so the held CPU request is not re-issued.
      S_IO_DONE: state_d = S_IDLE;
      S_UPG: begin
        cpu_stall = 1'b1;
        upg_ready = 1'b1;
        mem_addr  = upg_addr;
        mem_wdata = upg_wdata;
        if (upg_valid) begin
          mem_en = 1'b1;
          mem_we = 1'b1;
        end
        if (!upg_active) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IO request registers and CPU read-data latch; stores return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_req   <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= '0;
      io_wdata <= '0;
      rdata_q  <= '0;
    end else begin
      if (io_issue) begin
        io_req   <= 1'b1;
        io_we    <= cpu_io_write;
        io_addr  <= cpu_addr[IO_AW-1:0];
        io_wdata <= cpu_wdata;
      end
      if (io_complete) begin
        io_req  <= 1'b0;
        rdata_q <= io_we ? 32'h0 : io_rdata;
      end
      if (io_abort) begin
        io_req  <= 1'b0;
        rdata_q <= RDATA_ABORT;
      end
      if (rd_capture) rdata_q <= mem_rdata;
      if (st_clear)   rdata_q <= 32'h0;
    end
  end

`ifdef MEM_IO_ARB_WATCHDOG_EN
  arb_io_timer #(
    .LIMIT(IO_TIMEOUT)
  ) u_io_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (io_issue),
    .count    (state_q == S_IO_WAIT),
    .expire_c (wd_expire_c)
  );

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_timeout <= 1'b0;
    else if (io_abort) err_timeout <= 1'b1;
  end
`else
  assign wd_expire_c = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Upper address bits are outside the BRAM window.
  logic unused_c;
  assign unused_c = ^{cpu_addr[31:ADDR_W+2], IO_TIMEOUT[0]};

  // At most one CPU access strobe per cycle.
  assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({cpu_mem_read, cpu_mem_write, cpu_io_read, cpu_io_write}))
    else $error("mem_io_arbiter: multiple CPU strobes");

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Directed self-checking bench for mem_io_arbiter with a small BRAM model.
module tb_mem_io_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_mem_read, cpu_mem_write, cpu_io_read, cpu_io_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        upg_active, upg_valid, upg_ready;
  logic [13:0] upg_addr;
  logic [31:0] upg_wdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        io_req, io_we, io_ack;
  logic [9:0]  io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  logic [31:0] bram [16];

  always #5 clk = ~clk;

  mem_io_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_io_read(cpu_io_read), .cpu_io_write(cpu_io_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .upg_active(upg_active), .upg_valid(upg_valid), .upg_addr(upg_addr),
    .upg_wdata(upg_wdata), .upg_ready(upg_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack),
    .err_timeout(err_timeout)
  );

  // BRAM model: 16 words, synchronous write, 1-cycle registered read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr[3:0]] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr[3:0]];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle;
    cpu_mem_read = 0; cpu_mem_write = 0; cpu_io_read = 0; cpu_io_write = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cpu_idle(); cpu_addr = 0; cpu_wdata = 0;
    upg_active = 0; upg_valid = 0; upg_addr = 0; upg_wdata = 0;
    io_ack = 0; io_rdata = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%h exp=0", cpu_stall); end
    checks++; if (io_req !== 1'b0) begin errors++; $display("FAIL reset_io_req got=%h exp=0", io_req); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got=%h exp=0", err_timeout); end
    checks++; if ({mem_en, upg_ready} !== 2'b00) begin errors++; $display("FAIL reset_en_ready got=%b exp=00", {mem_en, upg_ready}); end
    rst_n = 1'b1;
  endtask

  task automatic test_mem_write;
    tick();
    cpu_mem_write = 1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hA5A5_0001;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, cpu_stall} !== 3'b110) begin errors++; $display("FAIL sw_ctrl got=%b exp=110", {mem_en, mem_we, cpu_stall}); end
    checks++; if (mem_addr !== 14'd4) begin errors++; $display("FAIL sw_addr got=%h exp=4", mem_addr); end
    checks++; if (mem_wdata !== 32'hA5A5_0001) begin errors++; $display("FAIL sw_wdata got=%h exp=a5a50001", mem_wdata); end
    tick();
    cpu_idle();
    @(negedge clk);
    checks++; if ({mem_en, cpu_stall} !== 2'b00) begin errors++; $display("FAIL sw_after got=%b exp=00", {mem_en, cpu_stall}); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL sw_rdata got=%h exp=0", cpu_rdata); end
  endtask

  task automatic test_mem_read(input logic [31:0] addr, input logic [31:0] exp);
    tick();
    cpu_mem_read = 1; cpu_addr = addr;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, cpu_stall} !== 3'b101) begin errors++; $display("FAIL lw_issue got=%b exp=101", {mem_en, mem_we, cpu_stall}); end
    tick();
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL lw_memrd_stall got=%h exp=0", cpu_stall); end
    checks++; if (cpu_rdata !== exp) begin errors++; $display("FAIL lw_memrd_rdata got=%h exp=%h", cpu_rdata, exp); end
    tick();
    cpu_idle();
    @(negedge clk);
    checks++; if ({cpu_stall, mem_en} !== 2'b00 || cpu_rdata !== exp) begin errors++; $display("FAIL lw_hold got=%b/%h exp=00/%h", {cpu_stall, mem_en}, cpu_rdata, exp); end
  endtask

  task automatic test_io_read;
    int stalls = 0;
    tick();
    cpu_io_read = 1; cpu_addr = 32'hFFFF_FC60;
    @(negedge clk);
    if (cpu_stall) stalls++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) begin io_ack = 1; io_rdata = 32'h0000_00FF; end
      @(negedge clk);
      if (cpu_stall) stalls++;
      if (k == 5) begin
        checks++; if ({io_req, io_we} !== 2'b10 || io_addr !== 10'h060) begin errors++; $display("FAIL ior_req got=%b/%h exp=10/060", {io_req, io_we}, io_addr); end
      end
    end
    tick();
    io_ack = 0; io_rdata = 0;
    @(negedge clk);
    checks++; if (stalls !== 6) begin errors++; $display("FAIL ior_stall_cycles got=%0d exp=6", stalls); end
    checks++; if ({cpu_stall, io_req} !== 2'b00) begin errors++; $display("FAIL ior_done got=%b exp=00", {cpu_stall, io_req}); end
    checks++; if (cpu_rdata !== 32'hFF) begin errors++; $display("FAIL ior_rdata got=%h exp=ff", cpu_rdata); end
    tick();
    cpu_idle();
    @(negedge clk);
    checks++; if ({cpu_stall, io_req} !== 2'b00) begin errors++; $display("FAIL ior_no_reissue got=%b exp=00", {cpu_stall, io_req}); end
    // Stray ack in IDLE must not disturb the latched data.
    tick();
    io_ack = 1; io_rdata = 32'h1234;
    tick();
    io_ack = 0; io_rdata = 0;
    @(negedge clk);
    checks++; if (cpu_rdata !== 32'hFF || cpu_stall !== 1'b0) begin errors++; $display("FAIL stray_ack got=%h/%h exp=ff/0", cpu_rdata, cpu_stall); end
  endtask

  task automatic test_upg_during_io;
    int writes = 0;
    tick();
    cpu_io_write = 1; cpu_addr = 32'hFFFF_FC04; cpu_wdata = 32'h55;
    tick();
    upg_active = 1;
    @(negedge clk);
    checks++; if ({upg_ready, cpu_stall, io_req, io_we} !== 4'b0111 || io_wdata !== 32'h55) begin errors++; $display("FAIL upg_io_wait got=%b/%h exp=0111/55", {upg_ready, cpu_stall, io_req, io_we}, io_wdata); end
    tick();
    io_ack = 1; io_rdata = 32'hDEAD;
    tick();
    io_ack = 0;
    @(negedge clk);
    checks++; if ({cpu_stall, upg_ready, mem_en} !== 3'b000 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL upg_io_done got=%b/%h exp=000/0", {cpu_stall, upg_ready, mem_en}, cpu_rdata); end
    tick();
    cpu_idle();
    @(negedge clk);
    checks++; if ({cpu_stall, mem_en, upg_ready} !== 3'b100) begin errors++; $display("FAIL upg_idle got=%b exp=100", {cpu_stall, mem_en, upg_ready}); end
    for (int w = 1; w <= 3; w++) begin
      tick();
      upg_valid = 1; upg_addr = 14'(w); upg_wdata = 32'h11 * w;
      @(negedge clk);
      if (mem_en && mem_we && upg_ready && cpu_stall && mem_addr == 14'(w)) writes++;
    end
    tick();
    upg_valid = 0; upg_active = 0;
    @(negedge clk);
    checks++; if (writes !== 3) begin errors++; $display("FAIL upg_writes got=%0d exp=3", writes); end
    checks++; if ({cpu_stall, upg_ready, mem_en} !== 3'b110) begin errors++; $display("FAIL upg_last got=%b exp=110", {cpu_stall, upg_ready, mem_en}); end
    tick();
    @(negedge clk);
    checks++; if ({cpu_stall, upg_ready} !== 2'b00) begin errors++; $display("FAIL upg_exit got=%b exp=00", {cpu_stall, upg_ready}); end
    test_mem_read(32'h0000_0008, 32'h22);
  endtask

  task automatic test_io_timeout;
    int req_cycles = 0;
    tick();
    cpu_io_write = 1; cpu_addr = 32'hFFFF_FC08; cpu_wdata = 32'h77;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      tick();
      @(negedge clk);
      if (!cpu_stall) break;
      if (io_req) req_cycles++;
    end
`ifdef MEM_IO_ARB_WATCHDOG_EN
    checks++; if (req_cycles !== 255) begin errors++; $display("FAIL wd_req_cycles got=%0d exp=255", req_cycles); end
    checks++; if ({cpu_stall, io_req, err_timeout} !== 3'b001 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL wd_abort got=%b/%h exp=001/0", {cpu_stall, io_req, err_timeout}, cpu_rdata); end
    tick();
    cpu_idle();
    repeat (3) tick();
    @(negedge clk);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%h exp=1", err_timeout); end
`else
    checks++; if (req_cycles !== 1000 || {cpu_stall, io_req, err_timeout} !== 3'b110) begin errors++; $display("FAIL nowd_wait got=%0d/%b exp=1000/110", req_cycles, {cpu_stall, io_req, err_timeout}); end
    tick();
    io_ack = 1;
    tick();
    io_ack = 0;
    @(negedge clk);
    checks++; if ({cpu_stall, io_req} !== 2'b00 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL nowd_done got=%b/%h exp=00/0", {cpu_stall, io_req}, cpu_rdata); end
    tick();
    cpu_idle();
`endif
  endtask

  task automatic test_reset_in_io;
    tick();
    cpu_io_read = 1; cpu_addr = 32'hFFFF_FC10;
    tick();
    @(negedge clk);
    checks++; if ({io_req, cpu_stall} !== 2'b11) begin errors++; $display("FAIL rst_pre got=%b exp=11", {io_req, cpu_stall}); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({io_req, cpu_stall, err_timeout} !== 3'b000 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_async got=%b/%h exp=000/0", {io_req, cpu_stall, err_timeout}, cpu_rdata); end
    cpu_idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cpu_mem_write = 1; cpu_addr = 32'h14; cpu_wdata = 32'h5;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, cpu_stall, io_req} !== 4'b1100 || mem_addr !== 14'd5) begin errors++; $display("FAIL rst_idle got=%b/%h exp=1100/5", {mem_en, mem_we, cpu_stall, io_req}, mem_addr); end
    tick();
    cpu_idle();
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_mem_read(32'h0000_0010, 32'hA5A5_0001);
    test_io_read();
    test_upg_during_io();
    test_io_timeout();
    test_reset_in_io();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
